// File: rtl/trap_sequencer_if.sv
// Redirect/flush bus between the trap sequencer (master) and the hazard unit / PC mux (slave).
interface trap_sequencer_if #(
  parameter int W = 64
);
  logic         flush;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         redirect_ack;

  modport master (
    output flush,
    output redirect_valid,
    output redirect_pc,
    input  redirect_ack
  );

  modport slave (
    input  flush,
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ack
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap sequencer: carries F-stage exceptions down to E, resolves priority, and runs trap entry / MRET return.
// Optional macro TRAP_SEQ_DOUBLE_FAULT_EN adds o_double_fault and a terminal HALT state.
module trap_sequencer #(
  parameter logic [1:0] XLEN      = 2'd2,
  parameter int         CODE_W    = 4,
  parameter int         FLUSH_CYC = 2,
  localparam int        W         = 1 << (XLEN + 4)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall_fd,
  input  logic              i_bubble_e,
  input  logic              i_exc_valid_f,
  input  logic [CODE_W-1:0] i_exc_code_f,
  input  logic [W-1:0]      i_tval_f,
  input  logic [W-1:0]      i_pc_e,
  input  logic              i_exc_valid_e,
  input  logic [CODE_W-1:0] i_exc_code_e,
  input  logic [W-1:0]      i_tval_e,
  input  logic              i_mret_e,
  input  logic [W-1:0]      i_mtvec,
  trap_sequencer_if.master  rd,
  output logic [W-1:0]      o_mepc,
  output logic [W-1:0]      o_mtval,
  output logic [CODE_W-1:0] o_mcause,
  output logic [1:0]        o_priv,
  output logic [1:0]        o_mpp,
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
  output logic              o_double_fault,
`endif
  output logic              o_busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FLUSH    = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
  localparam logic [1:0] S_HALT     = 2'd3;
`endif

  localparam logic [1:0] PRIV_M     = 2'b11;
  localparam logic [1:0] PRIV_U     = 2'b00;
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC);

  function automatic logic [W-1:0] align4(input logic [W-1:0] a);
    return a & ~W'(3);
  endfunction

  logic [1:0]        r_state;
  logic [2:0]        r_cnt;
  logic [W-1:0]      r_target;
  logic [W-1:0]      r_mepc;
  logic [W-1:0]      r_mtval;
  logic [CODE_W-1:0] r_mcause;
  logic [1:0]        r_priv;
  logic [1:0]        r_mpp;

  logic              r_vld_p0;
  logic [CODE_W-1:0] r_code_p0;
  logic [W-1:0]      r_tval_p0;
  logic              r_vld_p1;
  logic [CODE_W-1:0] r_code_p1;
  logic [W-1:0]      r_tval_p1;

  logic              w_flush;
  logic              w_req;
  logic [CODE_W-1:0] w_code;
  logic [W-1:0]      w_tval;
  logic [W-1:0]      w_base;

  // F->D (p0) and D->E (p1) exception pipe; flush dominates stall, bubble squashes entry into E
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_p0  <= 1'b0;
      r_code_p0 <= '0;
      r_tval_p0 <= '0;
      r_vld_p1  <= 1'b0;
      r_code_p1 <= '0;
      r_tval_p1 <= '0;
    end else begin
      if (w_flush) begin
        r_vld_p0 <= 1'b0;
        r_vld_p1 <= 1'b0;
      end else if (!i_stall_fd) begin
        r_vld_p0 <= i_exc_valid_f;
        r_vld_p1 <= r_vld_p0 & ~i_bubble_e;
      end else if (i_bubble_e) begin
        r_vld_p1 <= 1'b0;
      end
      if (!i_stall_fd) begin
        r_code_p0 <= i_exc_code_f;
        r_tval_p0 <= i_tval_f;
        r_code_p1 <= r_code_p0;
        r_tval_p1 <= r_tval_p0;
      end
    end
  end

  // E stage: an F-origin exception belongs to an older event of the same instruction, so it wins
  assign w_req  = r_vld_p1 | i_exc_valid_e;
  assign w_code = r_vld_p1 ? r_code_p1 : i_exc_code_e;
  assign w_tval = r_vld_p1 ? r_tval_p1 : i_tval_e;
  assign w_base = align4(i_mtvec);

`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
  logic r_in_trap;
  logic r_dfault;
  logic w_nested;

  // A fault raised by the handler's first instruction would loop forever through mtvec
  assign w_nested = w_req & r_in_trap & (r_priv == PRIV_M) & (i_pc_e == w_base);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_target <= '0;
      r_mepc   <= '0;
      r_mtval  <= '0;
      r_mcause <= '0;
      r_priv   <= PRIV_M;
      r_mpp    <= PRIV_U;
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
      r_in_trap <= 1'b0;
      r_dfault  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
          if (w_nested) begin
            r_dfault <= 1'b1;
            r_state  <= S_HALT;
          end else
`endif
          if (w_req) begin
            r_mepc   <= i_pc_e;
            r_mcause <= w_code;
            r_mtval  <= w_tval;
            r_mpp    <= r_priv;
            r_priv   <= PRIV_M;
            r_target <= w_base;
            r_cnt    <= FLUSH_INIT;
            r_state  <= S_FLUSH;
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
            r_in_trap <= 1'b1;
`endif
          end else if (i_mret_e) begin
            r_priv   <= r_mpp;
            r_mpp    <= PRIV_U;
            r_target <= r_mepc;
            r_cnt    <= FLUSH_INIT;
            r_state  <= S_FLUSH;
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
            r_in_trap <= 1'b0;
`endif
          end
        end
        S_FLUSH: begin
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
          if (w_req) begin
            r_dfault <= 1'b1;
            r_state  <= S_HALT;
          end else
`endif
          if (r_cnt <= 3'd1) begin
            r_state <= S_REDIRECT;
          end else begin
            r_cnt <= 3'(r_cnt - 3'd1);
          end
        end
        S_REDIRECT: begin
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
          if (w_req) begin
            r_dfault <= 1'b1;
            r_state  <= S_HALT;
          end else
`endif
          if (rd.redirect_ack) begin
            r_state <= S_IDLE;
          end
        end
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
        S_HALT: r_state <= S_HALT;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
  assign w_flush        = (r_state == S_FLUSH) | (r_state == S_HALT);
  assign o_double_fault = r_dfault;
`else
  assign w_flush = (r_state == S_FLUSH);
`endif

  assign rd.flush          = w_flush;
  assign rd.redirect_valid = (r_state == S_REDIRECT);
  assign rd.redirect_pc    = r_target;

  assign o_mepc   = r_mepc;
  assign o_mtval  = r_mtval;
  assign o_mcause = r_mcause;
  assign o_priv   = r_priv;
  assign o_mpp    = r_mpp;
  assign o_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed + randomized bench for trap_sequencer against an architectural trap-state model.
module tb_trap_sequencer;
  localparam int W  = 64;
  localparam int CW = 4;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall_fd, bubble_e, exc_valid_f, exc_valid_e, mret_e;
  logic [CW-1:0] exc_code_f, exc_code_e;
  logic [W-1:0]  tval_f, tval_e, pc_e, mtvec;
  logic [W-1:0]  mepc, mtval;
  logic [CW-1:0] mcause;
  logic [1:0]    priv, mpp;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Architectural expectations
  logic [1:0]    m_priv, m_mpp;
  logic [W-1:0]  m_mepc, m_mtval, m_target;
  logic [CW-1:0] m_mcause;

  trap_sequencer_if #(.W(W)) rd_if ();

  trap_sequencer #(.XLEN(2'd2), .CODE_W(CW), .FLUSH_CYC(FC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall_fd(stall_fd), .i_bubble_e(bubble_e),
    .i_exc_valid_f(exc_valid_f), .i_exc_code_f(exc_code_f), .i_tval_f(tval_f),
    .i_pc_e(pc_e), .i_exc_valid_e(exc_valid_e), .i_exc_code_e(exc_code_e), .i_tval_e(tval_e),
    .i_mret_e(mret_e), .i_mtvec(mtvec), .rd(rd_if),
    .o_mepc(mepc), .o_mtval(mtval), .o_mcause(mcause), .o_priv(priv), .o_mpp(mpp), .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    stall_fd = 0; bubble_e = 0; exc_valid_f = 0; exc_valid_e = 0; mret_e = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_priv = 2'b11; m_mpp = 2'b00; m_mepc = '0; m_mtval = '0; m_mcause = '0; m_target = '0;
  endtask

  task automatic model_trap(input logic [W-1:0] pc, input logic [CW-1:0] code, input logic [W-1:0] tv);
    m_mepc = pc; m_mcause = code; m_mtval = tv;
    m_mpp = m_priv; m_priv = 2'b11;
    m_target = {mtvec[W-1:2], 2'b00};
  endtask

  task automatic model_mret();
    m_priv = m_mpp; m_mpp = 2'b00; m_target = m_mepc;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_mepc"}, mepc, m_mepc);
    chk({tag, "_mcause"}, 64'(mcause), 64'(m_mcause));
    chk({tag, "_mtval"}, mtval, m_mtval);
    chk({tag, "_priv"}, 64'(priv), 64'(m_priv));
    chk({tag, "_mpp"}, 64'(mpp), 64'(m_mpp));
  endtask

  // Called in the cycle the request sits at E; follows flush, redirect and return to idle.
  task automatic run_seq(input string tag, input int ack_dly, input bit inject);
    int n, g;
    logic [W-1:0] pc_seen;
    tick();
    clr_in();
    n = 0; g = 0;
    while (!rd_if.redirect_valid && g < 16) begin
      if (rd_if.flush) n++;
      if (inject && g == 0) begin
        exc_valid_e = 1; exc_code_e = 4'd5; tval_e = 64'hDEAD;
        exc_valid_f = 1; exc_code_f = 4'd6; tval_f = 64'hBEEF;
      end
      tick();
      clr_in();
      g++;
    end
    chk({tag, "_redir_valid"}, 64'(rd_if.redirect_valid), 64'd1);
    chk({tag, "_flush_len"}, 64'(n), 64'(FC));
    chk({tag, "_redir_pc"}, rd_if.redirect_pc, m_target);
    chk({tag, "_flush_off"}, 64'(rd_if.flush), 64'd0);
    pc_seen = rd_if.redirect_pc;
    for (int k = 0; k < ack_dly; k++) begin
      tick();
      chk({tag, "_hold_valid"}, 64'(rd_if.redirect_valid), 64'd1);
      chk({tag, "_hold_pc"}, rd_if.redirect_pc, pc_seen);
    end
    rd_if.redirect_ack = 1;
    tick();
    rd_if.redirect_ack = 0;
    chk({tag, "_ack_valid"}, 64'(rd_if.redirect_valid), 64'd0);
    chk({tag, "_ack_idle"}, 64'(busy), 64'd0);
    chk_state(tag);
  endtask

  initial begin
    logic [W-1:0]  pcv, tf, te;
    logic [CW-1:0] cf, ce;
    int kind;

    clr_in();
    rst_n = 0; rd_if.redirect_ack = 0;
    exc_code_f = '0; exc_code_e = '0; tval_f = '0; tval_e = '0; pc_e = '0; mtvec = '0;
    model_reset();
    tick(); tick();
    chk("rst_priv", 64'(priv), 64'd3);
    chk("rst_flush", 64'(rd_if.flush), 64'd0);
    chk("rst_redir", 64'(rd_if.redirect_valid), 64'd0);
    chk("rst_mcause", 64'(mcause), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1;
    tick();

    // F-stage misaligned fetch travels two stages to E
    mtvec = 64'h8000_0003;
    exc_valid_f = 1; exc_code_f = 4'd0; tval_f = 64'h1002;
    tick(); clr_in(); tick();
    pc_e = 64'h1002;
    model_trap(64'h1002, 4'd0, 64'h1002);
    chk("fmis_target", m_target, 64'h8000_0000);
    run_seq("fmis", 0, 0);

    // F-origin beats E-origin on the same instruction
    tf = {$urandom, $urandom}; te = {$urandom, $urandom};
    exc_valid_f = 1; exc_code_f = 4'd2; tval_f = tf;
    tick(); clr_in(); tick();
    pc_e = 64'h2000; exc_valid_e = 1; exc_code_e = 4'd4; tval_e = te;
    model_trap(64'h2000, 4'd2, tf);
    run_seq("prio", 1, 0);

    // Bubble on the D->E edge squashes the pending F exception
    exc_valid_f = 1; exc_code_f = 4'd1; tval_f = 64'h3000;
    tick(); clr_in();
    bubble_e = 1;
    tick(); clr_in();
    chk("bubble_busy0", 64'(busy), 64'd0);
    tick();
    chk("bubble_busy1", 64'(busy), 64'd0);
    chk_state("bubble");

    // MRET twice to drop to U, ECALL from U, MRET back with a slow ack
    mret_e = 1; model_mret(); run_seq("mret1", 0, 0);
    mret_e = 1; model_mret(); run_seq("mret2", 0, 0);
    chk("user_priv", 64'(priv), 64'd0);
    pcv = 64'h0000_4444_0000_1230;
    pc_e = pcv; exc_valid_e = 1; exc_code_e = 4'd8; tval_e = '0;
    model_trap(pcv, 4'd8, '0);
    run_seq("ecall", 0, 0);
    mret_e = 1; model_mret(); run_seq("mret3", 5, 0);

    // Stall holds the F exception in D; it only reaches E once released
    exc_valid_f = 1; exc_code_f = 4'd3; tval_f = 64'h5555;
    tick(); clr_in();
    for (int k = 0; k < 3; k++) begin
      stall_fd = 1;
      tick();
      chk("stall_busy", 64'(busy), 64'd0);
    end
    clr_in();
    tick();
    pc_e = 64'h6000;
    model_trap(64'h6000, 4'd3, 64'h5555);
    run_seq("stall", 0, 0);

    // Requests during flush are ignored and flushed F exceptions never surface
    pc_e = 64'h7000; exc_valid_e = 1; exc_code_e = 4'd7; tval_e = 64'h77;
    model_trap(64'h7000, 4'd7, 64'h77);
    run_seq("busyign", 1, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("busyign_idle", 64'(busy), 64'd0);
    end

    // Randomized events: F, E, both, MRET, MRET with exception
    for (int it = 0; it < 16; it++) begin
      kind = int'($urandom_range(0, 4));
      pcv = {$urandom, $urandom}; mtvec = {$urandom, $urandom};
      cf = CW'($urandom_range(0, 15)); ce = CW'($urandom_range(0, 15));
      tf = {$urandom, $urandom}; te = {$urandom, $urandom};
      if (kind == 0 || kind == 2) begin
        exc_valid_f = 1; exc_code_f = cf; tval_f = tf;
        tick(); clr_in(); tick();
      end
      pc_e = pcv;
      if (kind == 1 || kind == 2 || kind == 4) begin
        exc_valid_e = 1; exc_code_e = ce; tval_e = te;
      end
      if (kind >= 3) mret_e = 1;
      if (kind == 0 || kind == 2) model_trap(pcv, cf, tf);
      else if (kind == 1 || kind == 4) model_trap(pcv, ce, te);
      else model_mret();
      run_seq("rand", int'($urandom_range(0, 3)), 0);
    end

    // Async reset in the middle of a flush
    pc_e = 64'h9000; exc_valid_e = 1; exc_code_e = 4'd11; tval_e = '0;
    tick(); clr_in();
    chk("arst_pre_flush", 64'(rd_if.flush), 64'd1);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("arst_flush", 64'(rd_if.flush), 64'd0);
    chk("arst_redir", 64'(rd_if.redirect_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk_state("arst");
    #2 rst_n = 1;
    tick();
    chk("arst_after", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
